instruction_fetch: RTL and testbench

Fetch stage of the five-stage MIPS pipeline, directly upstream of decode. Owns the program counter, issues word reads to instruction memory over a ready handshake, and holds the IF/ID pipeline register (`pc_id`, `instr_id`, `valid_id`) that decode consumes. Applies decode's stall and its branch/jump/jump-register redirects, honouring the MIPS branch delay slot.

---
 rtl/instruction_fetch.sv | 212 +++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: program counter, imem handshake, skid buffer and IF/ID register.
// Define FETCH_ALIGN_CHECK_EN to trap on misaligned redirect targets.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        valid_id,
    output logic        fetch_misaligned,
    output logic [31:0] fetch_bad_addr
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        TRAP  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        req_en_q;
    logic [31:0] pc_if_q;
    logic [31:0] pc_if_d;
    logic [31:0] pc_id_q;
    logic [31:0] pc_id_d;
    logic [31:0] instr_id_q;
    logic [31:0] instr_id_d;
    logic        valid_id_q;
    logic        valid_id_d;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_pc_d;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_instr_d;
    logic        pend_q;
    logic        pend_d;
    logic [31:0] pend_pc_q;
    logic [31:0] pend_pc_d;

    logic        advance;
    logic        accept;
    logic        redir;
    logic        deliver;
    logic        tgt_take;
    logic        take_bad;
    logic [31:0] pc_id_inc;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] redir_raw;
    logic [31:0] redir_pc;
    logic [31:0] tgt_use;
    logic [31:0] next_pc;

    assign advance   = ~stall;
    assign imem_req  = req_en_q & (state_q == FETCH);
    assign imem_addr = pc_if_q;
    assign accept    = imem_req & imem_ready;
    assign redir     = valid_id_q & advance
                     & (jump_reg | jump_target | jump_branch);

    assign pc_id_inc = pc_id_q + 32'd4;
    assign br_tgt    = pc_id_inc
                     + {{14{instr_id_q[15]}}, instr_id_q[15:0], 2'b00};
    assign j_tgt     = {pc_id_inc[31:28], instr_id_q[25:0], 2'b00};

    always_comb begin
        redir_raw = br_tgt;
        case (1'b1)
            jump_reg:    redir_raw = jr_pc;
            jump_target: redir_raw = j_tgt;
            default:     redir_raw = br_tgt;
        endcase
    end

    // A pending redirect belongs to the branch ahead of the slot; it wins.
    assign tgt_take = pend_q | redir;
    assign tgt_use  = pend_q ? pend_pc_q : redir_pc;
    assign next_pc  = tgt_take ? tgt_use : pc_if_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        mis_q;
    logic [31:0] bad_q;

    assign redir_pc = redir_raw;
    assign take_bad = tgt_take & (tgt_use[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q <= 1'b0;
            bad_q <= 32'h0;
        end else if (deliver & take_bad) begin
            mis_q <= 1'b1;
            bad_q <= tgt_use;
        end
    end

    assign fetch_misaligned = mis_q;
    assign fetch_bad_addr   = bad_q;
`else
    assign redir_pc         = redir_raw & 32'hFFFF_FFFC;
    assign take_bad         = 1'b0;
    assign fetch_misaligned = 1'b0;
    assign fetch_bad_addr   = 32'h0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_if_d      = pc_if_q;
        pc_id_d      = pc_id_q;
        instr_id_d   = instr_id_q;
        valid_id_d   = valid_id_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        deliver      = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (accept) begin
                    if (advance) begin
                        pc_id_d    = pc_if_q;
                        instr_id_d = imem_rdata;
                        valid_id_d = 1'b1;
                        deliver    = 1'b1;
                    end else begin
                        skid_pc_d    = pc_if_q;
                        skid_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end else if (advance) begin
                    valid_id_d = 1'b0;
                    // Delay slot still in flight: keep target for later.
                    if (redir) begin
                        pend_d    = 1'b1;
                        pend_pc_d = redir_pc;
                    end
                end
            end
            HOLD: begin
                if (advance) begin
                    pc_id_d    = skid_pc_q;
                    instr_id_d = skid_instr_q;
                    valid_id_d = 1'b1;
                    deliver    = 1'b1;
                end
            end
            TRAP: begin
                if (advance) begin
                    valid_id_d = 1'b0;
                end
            end
            default: state_d = FETCH;
        endcase
        if (deliver) begin
            pend_d = 1'b0;
            if (take_bad) begin
                state_d = TRAP;
            end else begin
                pc_if_d = next_pc;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests start one cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_en_q     <= 1'b0;
            pc_if_q      <= RESET_PC;
            pc_id_q      <= 32'h0;
            instr_id_q   <= 32'h0;
            valid_id_q   <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
            pend_q       <= 1'b0;
            pend_pc_q    <= 32'h0;
        end else begin
            req_en_q     <= 1'b1;
            pc_if_q      <= pc_if_d;
            pc_id_q      <= pc_id_d;
            instr_id_q   <= instr_id_d;
            valid_id_q   <= valid_id_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign pc_id    = pc_id_q;
    assign instr_id = instr_id_q;
    assign valid_id = valid_id_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized
// traffic checked against a program-order reference model.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        jump_branch = 1'b0;
    logic        jump_target = 1'b0;
    logic        jump_reg = 1'b0;
    logic [31:0] jr_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        valid_id;
    logic        fetch_misaligned;
    logic [31:0] fetch_bad_addr;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .jump_branch      (jump_branch),
        .jump_target      (jump_target),
        .jump_reg         (jump_reg),
        .jr_pc            (jr_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .pc_id            (pc_id),
        .instr_id         (instr_id),
        .valid_id         (valid_id),
        .fetch_misaligned (fetch_misaligned),
        .fetch_bad_addr   (fetch_bad_addr)
    );

    always #5 clk = ~clk;

    // Program image: BEQ offset 3 at the reset PC, hashed words elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h1000_0003;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic rdy,
                        input logic [2:0] fl, input logic [31:0] jr);
        stall = s;
        imem_ready = rdy;
        {jump_reg, jump_target, jump_branch} = fl;
        jr_pc = jr;
        @(negedge clk);
    endtask

    task automatic check_reset_vals();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", 32'(valid_id), 32'd0);
        check("rst_pc_id", pc_id, 32'h0);
        check("rst_instr", instr_id, 32'h0);
        check("rst_mis", 32'(fetch_misaligned), 32'd0);
        check("rst_bad", fetch_bad_addr, 32'h0);
    endtask

    logic [31:0] exp_pc;
    logic [31:0] tgt_q;
    logic [31:0] cur;
    logic [31:0] ins;
    logic [31:0] off;
    logic [31:0] tgt;
    logic [31:0] jr;
    logic [2:0]  fl;
    logic        tgt_pend;
    logic        s;
    logic        rdy;
    int          consumed;

    initial begin
        @(negedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait start-up and taken BEQ.
        step(1'b0, 1'b1, 3'b000, 32'h0);
        check("st_addr0", imem_addr, 32'h400);
        check("st_req", 32'(imem_req), 32'd1);
        check("st_valid0", 32'(valid_id), 32'd0);
        step(1'b0, 1'b1, 3'b000, 32'h0);
        check("st_addr1", imem_addr, 32'h404);
        check("st_valid1", 32'(valid_id), 32'd1);
        check("beq_pc", pc_id, 32'h400);
        check("beq_instr", instr_id, 32'h1000_0003);
        step(1'b0, 1'b1, 3'b001, 32'h0);
        check("slot_pc", pc_id, 32'h404);
        check("slot_valid", 32'(valid_id), 32'd1);
        check("br_addr", imem_addr, 32'h410);
        step(1'b0, 1'b1, 3'b000, 32'h0);
        check("br_tgt_pc", pc_id, 32'h410);
        check("br_next_addr", imem_addr, 32'h414);

        // Three wait cycles give three bubbles, address held.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'b000, 32'h0);
            check("bub_valid", 32'(valid_id), 32'd0);
            check("bub_addr", imem_addr, 32'h414);
        end
        step(1'b0, 1'b1, 3'b000, 32'h0);
        check("bub_end_pc", pc_id, 32'h414);
        check("bub_end_addr", imem_addr, 32'h418);

        // Two stall cycles while a word is accepted: skid then release.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 3'b000, 32'h0);
            check("hold_req", 32'(imem_req), 32'd0);
            check("hold_pc", pc_id, 32'h414);
            check("hold_instr", instr_id, mem_word(32'h414));
            check("hold_valid", 32'(valid_id), 32'd1);
        end
        step(1'b0, 1'b1, 3'b000, 32'h0);
        check("skid_pc", pc_id, 32'h418);
        check("skid_addr", imem_addr, 32'h41C);
        step(1'b0, 1'b1, 3'b000, 32'h0);
        check("skid_once", pc_id, 32'h41C);

        // JR with the slot fetch waiting two cycles.
        step(1'b0, 1'b0, 3'b100, 32'h1000);
        check("jr_wait_valid", 32'(valid_id), 32'd0);
        check("jr_wait_addr", imem_addr, 32'h420);
        step(1'b0, 1'b0, 3'b000, 32'h0);
        check("jr_wait_addr2", imem_addr, 32'h420);
        step(1'b0, 1'b1, 3'b000, 32'h0);
        check("jr_slot_pc", pc_id, 32'h420);
        check("jr_addr", imem_addr, 32'h1000);
        step(1'b0, 1'b1, 3'b000, 32'h0);
        check("jr_tgt_pc", pc_id, 32'h1000);

        // Misaligned JR target.
        step(1'b0, 1'b1, 3'b100, 32'h1002);
        check("mj_slot_pc", pc_id, 32'h1004);
        check("mj_slot_valid", 32'(valid_id), 32'd1);
`ifdef FETCH_ALIGN_CHECK_EN
        check("trap_mis", 32'(fetch_misaligned), 32'd1);
        check("trap_bad", fetch_bad_addr, 32'h1002);
        check("trap_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 3'b000, 32'h0);
            check("trap_valid", 32'(valid_id), 32'd0);
            check("trap_req_h", 32'(imem_req), 32'd0);
            check("trap_mis_h", 32'(fetch_misaligned), 32'd1);
        end
`else
        check("mask_mis", 32'(fetch_misaligned), 32'd0);
        check("mask_addr", imem_addr, 32'h1000);
        step(1'b0, 1'b1, 3'b000, 32'h0);
        check("mask_pc", pc_id, 32'h1000);
`endif

        // Reset asserted while a fetch is waiting.
        step(1'b0, 1'b0, 3'b000, 32'h0);
        rst = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the program-order model.
        exp_pc = RST_PC;
        tgt_pend = 1'b0;
        tgt_q = 32'h0;
        consumed = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            s = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
`ifdef FETCH_ALIGN_CHECK_EN
            jr = $urandom & 32'hFFFF_FFFC;
`else
            jr = $urandom;
`endif
            fl = 3'($urandom_range(0, 7));
            if (valid_id && !s) begin
                cur = exp_pc;
                ins = mem_word(cur);
                check("rnd_pc", pc_id, cur);
                check("rnd_instr", instr_id, ins);
                consumed++;
                if (tgt_pend || $urandom_range(0, 2) != 0) fl = 3'b000;
                if (tgt_pend) begin
                    exp_pc = tgt_q;
                    tgt_pend = 1'b0;
                end else begin
                    exp_pc = cur + 32'd4;
                end
                if (fl != 3'b000) begin
                    off = {{16{ins[15]}}, ins[15:0]};
                    if (fl[2]) tgt = jr & 32'hFFFF_FFFC;
                    else if (fl[1]) tgt = {exp_pc[31:28], ins[25:0], 2'b00};
                    else tgt = cur + 32'd4 + (off << 2);
                    if (fl[1] && !fl[2])
                        tgt = {cur[31:28] + ((cur[27:0] > 28'hFFFFFFB) ? 4'd1 : 4'd0),
                               ins[25:0], 2'b00};
                    tgt_q = tgt;
                    tgt_pend = 1'b1;
                end
            end
            step(s, rdy, fl, jr);
        end
        check("rnd_consumed", 32'(consumed >= 1000), 32'd1);
        check("rnd_no_trap", 32'(fetch_misaligned), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
